// File: rtl/addsub_pkg.sv
// Shared definitions for the add/subtract pipeline: operation encoding and
// the signed saturation limits used when ADDSUB_SAT_EN is defined.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_ACC_ADD = 2'b10,
    OP_ACC_SUB = 2'b11
  } op_e;

  localparam int SAT_MAX_WIDTH = 64;

  // Signed extreme for a width: 100..0 when neg, else 011..1 (low bits used).
  function automatic logic [SAT_MAX_WIDTH-1:0] signed_extreme(input int width, input logic neg);
    logic [SAT_MAX_WIDTH-1:0] msb;
    msb = 64'd1 << (width - 1);
    return neg ? msb : (msb - 64'd1);
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit adder/subtractor: sum = x + (sub ? ~b : b) + sub,
// with carry out of the MSB and two's-complement overflow.
module addsub_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_full;

  assign w_b_eff = i_sub ? ~i_b : i_b;
  assign w_full  = {1'b0, i_x} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, i_sub};

  assign o_sum      = w_full[WIDTH-1:0];
  assign o_carry    = w_full[WIDTH];
  // Like-signed operands whose result flips sign have overflowed.
  assign o_overflow = (i_x[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_full[WIDTH-1] != i_x[WIDTH-1]);

endmodule

// File: rtl/addsub_pipe.sv
// Two-stage pipelined add/sub unit with running accumulator and flags.
// Optional build macro ADDSUB_SAT_EN: saturate s (and acc) on signed overflow.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic [WIDTH-1:0] acc
);

  // Handshakes: a beat moves on a rising edge where valid && ready are both
  // high; valid never depends on ready, and a held beat keeps its data stable.

  logic             r_s1_valid;
  op_e              r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s;
  logic             r_carry;
  logic             r_overflow;
  logic             r_zero;
  logic [WIDTH-1:0] r_acc;

  logic             w_s2_load;
  logic             w_in_fire;
  logic             w_sub;
  logic             w_use_acc;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_sum;
  logic             w_carry;
  logic             w_overflow;
  logic [WIDTH-1:0] w_s_final;

  assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_in_fire = in_valid && in_ready;

  assign w_sub     = (r_s1_op == OP_SUB) || (r_s1_op == OP_ACC_SUB);
  assign w_use_acc = (r_s1_op == OP_ACC_ADD) || (r_s1_op == OP_ACC_SUB);
  // acc is read at S2 load, so every earlier ACC op has already written it.
  assign w_x       = w_use_acc ? r_acc : r_s1_a;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .i_x        (w_x),
    .i_b        (r_s1_b),
    .i_sub      (w_sub),
    .o_sum      (w_sum),
    .o_carry    (w_carry),
    .o_overflow (w_overflow)
  );

`ifdef ADDSUB_SAT_EN
  // Overflow direction follows the sign of X (both operands share it).
  assign w_s_final = w_overflow ? WIDTH'(signed_extreme(WIDTH, w_x[WIDTH-1])) : w_sum;
`else
  assign w_s_final = w_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_ADD;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_op    <= op_e'(op);
      r_s1_a     <= a;
      r_s1_b     <= b;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s        <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= 1'b1;
      r_s        <= w_s_final;
      r_carry    <= w_carry;
      r_overflow <= w_overflow;
      r_zero     <= (w_s_final == '0);
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  // A clear in the same cycle as an ACC load wins over the write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (acc_clr) begin
      r_acc <= '0;
    end else if (w_s2_load && w_use_acc) begin
      r_acc <= w_s_final;
    end
  end

  assign out_valid = r_s2_valid;
  assign s         = r_s;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign zero      = r_zero;
  assign acc       = r_acc;

endmodule
